// File: rtl/md6_seq_stream_ctrl_pkg.sv
// Shared MD6 SEQ-mode constants, the SEQ chaining IV and the controller state encoding.
package md6_seq_stream_ctrl_pkg;

    // MD6 word width (w) and chaining words per compression output (c)
    localparam int MD6_W     = 64;
    localparam int MD6_C     = 16;
    // A compression input block is always 64 words: message part plus chaining part
    localparam int MD6_B     = 64;
    localparam int MD6_BW    = MD6_B - MD6_C;
    localparam int MD6_IDX_W = 56;
    localparam int MD6_LEVEL = 1;
    localparam int PAD_W     = 12;

    // Sequential mode starts every message from an all-zero chaining value
    localparam logic MD6_SEQ_IV_BIT = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DRAIN = 3'd4
    } seq_state_t;

    // A block is final when the sender says so, or when the index space is exhausted
    function automatic logic seq_final(input logic last, input logic idx_at_max);
        return last | idx_at_max;
    endfunction

endpackage

// File: rtl/md6_seq_stream_ctrl_idx_ctr.sv
// Block index counter U: clears to zero, increments per chained block, flags the last legal value.
module md6_seq_stream_ctrl_idx_ctr #(
    parameter int IDX_W = 56
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             at_max
);

    // Clear wins over increment so an abort or message end always restarts at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    assign at_max = &idx;

endmodule

// File: rtl/md6_seq_stream_ctrl.sv
// MD6 sequential-mode chaining controller: takes message blocks on a stream, drives an
// external compression function one block at a time, and returns the final chaining value.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// A source holds valid and its payload stable until that edge; ready may change freely.
// This applies to s_valid/s_ready and to h_valid/h_ready.
module md6_seq_stream_ctrl
    import md6_seq_stream_ctrl_pkg::*;
#(
    parameter int W     = MD6_W,
    parameter int CW    = MD6_C,
    parameter int BW    = MD6_BW,
    parameter int IDX_W = MD6_IDX_W,
    parameter int LEVEL = MD6_LEVEL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   abort,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [BW*W-1:0]        s_data,
    input  logic                   s_last,
    input  logic [PAD_W-1:0]       s_pad,
    output logic                   cf_start,
    output logic [(BW+CW)*W-1:0]   cf_B,
    output logic [IDX_W-1:0]       cf_index,
    output logic [7:0]             cf_level,
    output logic                   cf_z,
    output logic [PAD_W-1:0]       cf_p,
    input  logic                   cf_done,
    input  logic [CW*W-1:0]        cf_C,
    output logic                   h_valid,
    input  logic                   h_ready,
    output logic [CW*W-1:0]        h_data,
    output logic                   busy,
    output logic                   err_ovf,
    output logic [2:0]             dbg_state
);

    seq_state_t           state;
    logic [BW*W-1:0]      data_q;
    logic [CW*W-1:0]      chain_q;
    logic [CW*W-1:0]      h_data_q;
    logic [PAD_W-1:0]     pad_q;
    logic                 z_q;
    logic                 s_ready_q;
    logic                 cf_start_q;
    logic                 h_valid_q;
    logic                 err_ovf_q;
    logic                 idx_clr;
    logic                 idx_inc;
    logic                 idx_at_max;
    logic [IDX_W-1:0]     idx;
    logic                 abort_flush;

    // Abort drops the message immediately everywhere except while a cf call is outstanding
    assign abort_flush = abort && (state != ST_WAIT) && (state != ST_DRAIN);

    // Index counter control: restart on flush/message end, advance when a non-final block chains
    always_comb begin
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        if (abort_flush) begin
            idx_clr = 1'b1;
        end else if (state == ST_DRAIN && cf_done) begin
            idx_clr = 1'b1;
        end else if (state == ST_OUT && h_ready) begin
            idx_clr = 1'b1;
        end else if (state == ST_WAIT && !abort && cf_done && !z_q) begin
            idx_inc = 1'b1;
        end
    end

    md6_seq_stream_ctrl_idx_ctr #(
        .IDX_W (IDX_W)
    ) u_idx_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr    (idx_clr),
        .inc    (idx_inc),
        .idx    (idx),
        .at_max (idx_at_max)
    );

    // Sequencer: one block in flight; in DRAIN, cf_done completes the drop even if abort is still high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            data_q     <= '0;
            chain_q    <= {(CW*W){MD6_SEQ_IV_BIT}};
            h_data_q   <= '0;
            pad_q      <= '0;
            z_q        <= 1'b0;
            s_ready_q  <= 1'b1;
            cf_start_q <= 1'b0;
            h_valid_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else if (abort_flush) begin
            state      <= ST_IDLE;
            chain_q    <= {(CW*W){MD6_SEQ_IV_BIT}};
            s_ready_q  <= 1'b1;
            cf_start_q <= 1'b0;
            h_valid_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        data_q     <= s_data;
                        pad_q      <= s_pad;
                        z_q        <= seq_final(s_last, idx_at_max);
                        if (idx_at_max && !s_last) begin
                            err_ovf_q <= 1'b1;
                        end
                        s_ready_q  <= 1'b0;
                        cf_start_q <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cf_start_q <= 1'b0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (abort) begin
                        state <= ST_DRAIN;
                    end else if (cf_done) begin
                        if (z_q) begin
                            h_data_q  <= cf_C;
                            h_valid_q <= 1'b1;
                            state     <= ST_OUT;
                        end else begin
                            chain_q   <= cf_C;
                            s_ready_q <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                ST_OUT: begin
                    if (h_ready) begin
                        h_valid_q <= 1'b0;
                        chain_q   <= {(CW*W){MD6_SEQ_IV_BIT}};
                        s_ready_q <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (cf_done) begin
                        chain_q   <= {(CW*W){MD6_SEQ_IV_BIT}};
                        s_ready_q <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    s_ready_q  <= 1'b1;
                    cf_start_q <= 1'b0;
                    h_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Abort masks ready and start in the same cycle so neither side sees a transfer that is dropped
    assign s_ready   = s_ready_q & ~abort;
    assign cf_start  = cf_start_q & ~abort;
    assign cf_B      = {data_q, chain_q};
    assign cf_index  = idx;
    assign cf_level  = 8'(LEVEL);
    assign cf_z      = z_q;
    assign cf_p      = pad_q;
    assign h_valid   = h_valid_q;
    assign h_data    = h_data_q;
    assign busy      = (state != ST_IDLE);
    assign err_ovf   = err_ovf_q;
    assign dbg_state = state;

endmodule
